// File: rtl/esp_spi_pkg.sv
// Shared types and constants for the ESP32 SPI link: slave FSM encoding,
// receive-side payload struct and the command opcodes seen by the decoder.
package esp_spi_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] spi_state_t;

  localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd1;
  localparam logic [STATE_W-1:0] ST_ACTIVE    = 2'd2;

  localparam logic [BYTE_W-1:0] CMD_BUS_ACQUIRE = 8'h20;
  localparam logic [BYTE_W-1:0] CMD_BUS_RELEASE = 8'h21;
  localparam logic [BYTE_W-1:0] CMD_MEM_WR      = 8'h22;
  localparam logic [BYTE_W-1:0] CMD_MEM_RD      = 8'h23;
  localparam logic [BYTE_W-1:0] CMD_SET_BANK    = 8'h24;

  // One received byte as handed to the command decoder.
  typedef struct packed {
    logic              valid;
    logic              first;
    logic [BYTE_W-1:0] data;
  } rx_beat_t;

endpackage

// File: rtl/esp_spi_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a registered
// level and single-cycle rise/fall strobes aligned to that level.
module esp_spi_slave_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("esp_spi_slave_sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;

  // level_q is the "previous" copy; strobes compare it to the last sync stage.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    level_d = sync_q[SYNC_STAGES-1];
    rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
    fall_d  = ~sync_q[SYNC_STAGES-1] & level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/esp_spi_slave.sv
// Oversampled SPI mode-0 slave for the ESP32 link: assembles MOSI bytes with
// frame markers for the command decoder and shifts response bytes out on MISO.
module esp_spi_slave
  import esp_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ssel_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [BYTE_W-1:0] rxdata,
  output logic              rxdata_valid,
  output logic              rxdata_first,
  output logic              msg_start,
  output logic              msg_end,
  input  logic [BYTE_W-1:0] txdata,
  output logic              txdata_ack
);

  logic ssel_n_lvl;
  logic ssel_n_rise;
  logic ssel_n_fall;
  logic sclk_lvl;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_lvl;
  logic mosi_rise;
  logic mosi_fall;

  esp_spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ssel (
    .clk   (clk),
    .reset (reset),
    .d     (spi_ssel_n),
    .level (ssel_n_lvl),
    .rise  (ssel_n_rise),
    .fall  (ssel_n_fall)
  );

  esp_spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .d     (spi_sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // Same pipeline depth as sclk so the sampled bit lines up with sclk_rise.
  esp_spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .d     (spi_mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  spi_state_t        state_q;
  spi_state_t        state_d;
  logic [CNT_W-1:0]  bitcnt_q;
  logic [CNT_W-1:0]  bitcnt_d;
  logic              first_flag_q;
  logic              first_flag_d;
  logic [BYTE_W-1:0] rx_shift_q;
  logic [BYTE_W-1:0] rx_shift_d;
  logic [BYTE_W-1:0] tx_shift_q;
  logic [BYTE_W-1:0] tx_shift_d;
  rx_beat_t          rx_out_q;
  rx_beat_t          rx_out_d;
  logic              msg_start_q;
  logic              msg_start_d;
  logic              msg_end_q;
  logic              msg_end_d;
  logic              txdata_ack_q;
  logic              txdata_ack_d;
  logic              spi_miso_q;
  logic              spi_miso_d;
  logic              spi_miso_oe_q;
  logic              spi_miso_oe_d;

  // Frame FSM plus RX/TX shifters; ssel deassertion outranks any sclk edge.
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    first_flag_d  = first_flag_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_out_d      = rx_out_q;
    rx_out_d.valid = 1'b0;
    rx_out_d.first = 1'b0;
    msg_start_d   = 1'b0;
    msg_end_d     = 1'b0;
    txdata_ack_d  = 1'b0;

    case (state_q)
      ST_WAIT_IDLE: begin
        if (ssel_n_lvl) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (ssel_n_fall) begin
          state_d      = ST_ACTIVE;
          msg_start_d  = 1'b1;
          txdata_ack_d = 1'b1;
          tx_shift_d   = txdata;
          bitcnt_d     = '0;
          first_flag_d = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (ssel_n_rise) begin
          state_d   = ST_IDLE;
          msg_end_d = 1'b1;
          bitcnt_d  = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_lvl};
          bitcnt_d   = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == CNT_W'(BYTE_W - 1)) begin
            rx_out_d.data  = {rx_shift_q[BYTE_W-2:0], mosi_lvl};
            rx_out_d.valid = 1'b1;
            rx_out_d.first = first_flag_q;
            first_flag_d   = 1'b0;
          end
        end else if (sclk_fall) begin
          if (bitcnt_q != '0) begin
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
          end else begin
            tx_shift_d   = txdata;
            txdata_ack_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_WAIT_IDLE;
      end
    endcase

    spi_miso_oe_d = (state_d == ST_ACTIVE);
    spi_miso_d    = (state_d == ST_ACTIVE) & tx_shift_d[BYTE_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT_IDLE;
      bitcnt_q      <= '0;
      first_flag_q  <= 1'b0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_out_q      <= '0;
      msg_start_q   <= 1'b0;
      msg_end_q     <= 1'b0;
      txdata_ack_q  <= 1'b0;
      spi_miso_q    <= 1'b0;
      spi_miso_oe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      first_flag_q  <= first_flag_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_out_q      <= rx_out_d;
      msg_start_q   <= msg_start_d;
      msg_end_q     <= msg_end_d;
      txdata_ack_q  <= txdata_ack_d;
      spi_miso_q    <= spi_miso_d;
      spi_miso_oe_q <= spi_miso_oe_d;
    end
  end

  assign spi_miso     = spi_miso_q;
  assign spi_miso_oe  = spi_miso_oe_q;
  assign rxdata       = rx_out_q.data;
  assign rxdata_valid = rx_out_q.valid;
  assign rxdata_first = rx_out_q.first;
  assign msg_start    = msg_start_q;
  assign msg_end      = msg_end_q;
  assign txdata_ack   = txdata_ack_q;

endmodule

// File: tb/tb_esp_spi_slave.sv
// Directed and randomized frames driven by a bit-banged SPI master; received
// bytes, MISO bytes and frame pulses are checked against per-frame expectations.
module tb_esp_spi_slave;

  localparam int HALF = 7;  // clk periods per SCLK phase (~1 MHz SCLK)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_ssel_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rxdata;
  logic       rxdata_valid;
  logic       rxdata_first;
  logic       msg_start;
  logic       msg_end;
  logic [7:0] txdata = 8'h00;
  logic       txdata_ack;

  esp_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_ssel_n   (spi_ssel_n),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .rxdata       (rxdata),
    .rxdata_valid (rxdata_valid),
    .rxdata_first (rxdata_first),
    .msg_start    (msg_start),
    .msg_end      (msg_end),
    .txdata       (txdata),
    .txdata_ack   (txdata_ack)
  );

  always #35 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observed activity, recorded on the falling edge.
  int         n_valid = 0;
  int         n_start = 0;
  int         n_end = 0;
  int         n_ack = 0;
  int         proto_bad = 0;
  logic [7:0] rx_log[$];
  logic       first_log[$];
  bit         in_frame = 1'b0;
  bit         rst_d = 1'b1;

  always @(negedge clk) begin
    if (reset || rst_d) begin
      in_frame = 1'b0;
    end else begin
      if (spi_miso_oe !== (msg_start | (in_frame & ~msg_end))) proto_bad++;
      if (spi_miso_oe !== 1'b1 && spi_miso !== 1'b0) proto_bad++;
      if (rxdata_valid !== 1'b1 && rxdata_first !== 1'b0) proto_bad++;
      if (msg_start === 1'b1) begin in_frame = 1'b1; n_start++; end
      if (msg_end === 1'b1) begin in_frame = 1'b0; n_end++; end
      if (txdata_ack === 1'b1) n_ack++;
      if (rxdata_valid === 1'b1) begin
        n_valid++;
        rx_log.push_back(rxdata);
        first_log.push_back(rxdata_first);
      end
    end
    rst_d = reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte (or fewer bits) as an SPI mode-0 master; optional end of frame
  // with ssel released together with the final sclk fall.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                      input bit lat, input logic [7:0] next_tx, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      mi = {mi[6:0], spi_miso};
      if (i == 0) txdata = next_tx;
      if (lat && i == 7) begin
        repeat (3) @(negedge clk);
        chk("lat_early", 32'(rxdata_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(rxdata_valid), 32'd1);
        chk("lat_data", 32'(rxdata), 32'(mo));
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (last && i == nbits - 1) spi_ssel_n = 1'b1;
      spi_sclk = 1'b0;
    end
  endtask

  logic [7:0] f_mo[4];
  logic [7:0] f_tx[5];

  // Reference: every byte of a complete frame is received in order, only the
  // first is flagged first, MISO carries the response bytes, one ack per byte.
  task automatic frame(input int n, input bit lat);
    logic [7:0] mi;
    int v0, s0, e0, a0, q0;
    v0 = n_valid; s0 = n_start; e0 = n_end; a0 = n_ack; q0 = rx_log.size();
    txdata = f_tx[0];
    spi_ssel_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      xfer(f_mo[b], 8, b == n - 1, lat && (b == n - 1), f_tx[b+1], mi);
      chk("miso_byte", 32'(mi), 32'(f_tx[b]));
    end
    repeat (10) @(negedge clk);
    chk("rx_count", 32'(n_valid - v0), 32'(n));
    for (int b = 0; b < n; b++) begin
      if (q0 + b < rx_log.size()) begin
        chk("rx_data", 32'(rx_log[q0+b]), 32'(f_mo[b]));
        chk("rx_first", 32'(first_log[q0+b]), 32'(b == 0));
      end
    end
    chk("msg_start_cnt", 32'(n_start - s0), 32'd1);
    chk("msg_end_cnt", 32'(n_end - e0), 32'd1);
    chk("ack_cnt", 32'(n_ack - a0), 32'(n));
  endtask

  initial begin
    logic [7:0] mi;
    int v0, s0, e0, a0, n;

    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_rxdata", 32'(rxdata), 32'd0);
    chk("rst_valid", 32'(rxdata_valid), 32'd0);
    chk("rst_first", 32'(rxdata_first), 32'd0);
    chk("rst_start", 32'(msg_start), 32'd0);
    chk("rst_end", 32'(msg_end), 32'd0);
    chk("rst_ack", 32'(txdata_ack), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // sclk and mosi activity with ssel high
    v0 = n_valid; s0 = n_start; a0 = n_ack;
    for (int i = 0; i < 12; i++) begin
      spi_mosi = 1'($urandom);
      spi_sclk = 1'b1; repeat (4) @(negedge clk);
      spi_sclk = 1'b0; repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("glitch_valid", 32'(n_valid - v0), 32'd0);
    chk("glitch_start", 32'(n_start - s0), 32'd0);
    chk("glitch_ack", 32'(n_ack - a0), 32'd0);

    // Command frame 22 55 55 AA
    f_mo[0] = 8'h22; f_mo[1] = 8'h55; f_mo[2] = 8'h55; f_mo[3] = 8'hAA;
    for (int i = 0; i < 5; i++) f_tx[i] = 8'($urandom);
    frame(4, 1'b1);

    // Two-byte response A5 then 3C
    f_mo[0] = 8'($urandom); f_mo[1] = 8'($urandom);
    f_tx[0] = 8'hA5; f_tx[1] = 8'h3C; f_tx[2] = 8'h00;
    frame(2, 1'b0);

    // Aborted byte: 5 bits of 0x24, then a clean 0x21 frame
    v0 = n_valid; s0 = n_start; e0 = n_end;
    txdata = 8'($urandom);
    spi_ssel_n = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'h24, 5, 1'b1, 1'b0, 8'h00, mi);
    repeat (10) @(negedge clk);
    chk("abort_valid", 32'(n_valid - v0), 32'd0);
    chk("abort_start", 32'(n_start - s0), 32'd1);
    chk("abort_end", 32'(n_end - e0), 32'd1);
    f_mo[0] = 8'h21; f_tx[0] = 8'($urandom); f_tx[1] = 8'h00;
    frame(1, 1'b1);

    // Empty frame: ssel low ~2 us with no sclk
    v0 = n_valid; s0 = n_start; e0 = n_end; a0 = n_ack;
    spi_ssel_n = 1'b0;
    repeat (29) @(negedge clk);
    spi_ssel_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("empty_start", 32'(n_start - s0), 32'd1);
    chk("empty_ack", 32'(n_ack - a0), 32'd1);
    chk("empty_end", 32'(n_end - e0), 32'd1);
    chk("empty_valid", 32'(n_valid - v0), 32'd0);

    // Reset in the middle of a frame; the rest of that frame must be ignored
    spi_ssel_n = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'($urandom), 3, 1'b0, 1'b0, 8'h00, mi);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    v0 = n_valid; s0 = n_start; e0 = n_end;
    for (int b = 0; b < 3; b++) xfer(8'($urandom), 8, 1'b0, 1'b0, 8'h00, mi);
    repeat (HALF) @(negedge clk);
    spi_ssel_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_valid", 32'(n_valid - v0), 32'd0);
    chk("rstmid_start", 32'(n_start - s0), 32'd0);
    chk("rstmid_end", 32'(n_end - e0), 32'd0);
    f_mo[0] = 8'h20; f_tx[0] = 8'($urandom); f_tx[1] = 8'h00;
    frame(1, 1'b1);

    // Random frames
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 4));
      for (int b = 0; b < 4; b++) f_mo[b] = 8'($urandom);
      for (int b = 0; b < 5; b++) f_tx[b] = 8'($urandom);
      frame(n, 1'($urandom));
    end

    chk("oe_miso_protocol", 32'(proto_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
